// File: rtl/enemy_ai_ctrl.sv
// rtl/enemy_ai_ctrl.sv - per-enemy direction controller for Keese, ReDead and Slider behaviours
// Optional feature macro: ENEMY_AI_STALL_DETECT_EN (position-stall reaction).
module enemy_ai_ctrl #(
    parameter int unsigned HOLD_FRAMES  = 32,
    parameter int unsigned PAUSE_FRAMES = 16,
    parameter int unsigned CHASE_RADIUS = 160,
    parameter int unsigned ALIGN_TOL    = 8,
    parameter int unsigned SLIDE_FRAMES = 48,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic       initialize,
    input  logic       active,
    input  logic [1:0] Enemy_Type,
    input  logic [9:0] Enemy_X,
    input  logic [9:0] Enemy_Y,
    input  logic [9:0] Link_X,
    input  logic [9:0] Link_Y,
    output logic [2:0] dir
);
    typedef enum logic [2:0] {
        ST_IDLE, ST_WALK, ST_CHASE, ST_SLIDE, ST_RETURN, ST_COOLDOWN
    } state_e;

    localparam logic [2:0] DIR_STOP  = 3'd0;
    localparam logic [2:0] DIR_LEFT  = 3'd1;
    localparam logic [2:0] DIR_RIGHT = 3'd2;
    localparam logic [2:0] DIR_DOWN  = 3'd3;
    localparam logic [2:0] DIR_UP    = 3'd4;
    localparam logic [1:0] TYPE_KEESE  = 2'd1;
    localparam logic [1:0] TYPE_REDEAD = 2'd2;
    localparam logic [1:0] TYPE_SLIDER = 2'd3;
    localparam logic [7:0] HOLD_LAST  = 8'(HOLD_FRAMES - 1);
    localparam logic [7:0] PAUSE_LAST = 8'(PAUSE_FRAMES - 1);
    localparam logic [7:0] SLIDE_LAST = 8'(SLIDE_FRAMES - 1);
    localparam logic [7:0] SLIDE_CNT  = 8'(SLIDE_FRAMES);
    localparam logic [9:0] RADIUS     = 10'(CHASE_RADIUS);
    localparam logic [9:0] TOL        = 10'(ALIGN_TOL);

    state_e      state_q, state_d;
    logic [2:0]  dir_q, dir_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        frame_q, frame_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [1:0]  type_q, type_d;
    logic        fclk_dly_q, fclk_dly_d;

    logic        frame_tick, stall;
    logic [10:0] dx, dy;
    logic [9:0]  abs_dx, abs_dy;
    logic [2:0]  x_dir, y_dir, chase_dir, roll_dir, opp_dir;

    assign fclk_dly_d = frame_clk;
    assign frame_tick = frame_clk & ~fclk_dly_q;

    // Geometry: 11-bit differences, sign from bit 10, magnitude recomputed without wrap.
    assign dx        = {1'b0, Link_X} - {1'b0, Enemy_X};
    assign dy        = {1'b0, Link_Y} - {1'b0, Enemy_Y};
    assign abs_dx    = dx[10] ? (Enemy_X - Link_X) : (Link_X - Enemy_X);
    assign abs_dy    = dy[10] ? (Enemy_Y - Link_Y) : (Link_Y - Enemy_Y);
    assign x_dir     = (dx == 11'd0) ? DIR_STOP : (dx[10] ? DIR_LEFT : DIR_RIGHT);
    assign y_dir     = (dy == 11'd0) ? DIR_STOP : (dy[10] ? DIR_UP : DIR_DOWN);
    assign chase_dir = (abs_dx >= abs_dy) ? x_dir : y_dir;
    assign roll_dir  = {1'b0, lfsr_q[1:0]} + 3'd1;

    always_comb begin
        opp_dir = DIR_STOP;
        case (dir_q)
            DIR_LEFT:  opp_dir = DIR_RIGHT;
            DIR_RIGHT: opp_dir = DIR_LEFT;
            DIR_DOWN:  opp_dir = DIR_UP;
            DIR_UP:    opp_dir = DIR_DOWN;
            default:   opp_dir = DIR_STOP;
        endcase
    end

    assign lfsr_d = frame_tick ? ({1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000))
                               : lfsr_q;

`ifdef ENEMY_AI_STALL_DETECT_EN
    logic [9:0] prev_x_q, prev_x_d, prev_y_q, prev_y_d;
    assign prev_x_d = frame_tick ? Enemy_X : prev_x_q;
    assign prev_y_d = frame_tick ? Enemy_Y : prev_y_q;
    assign stall    = (Enemy_X == prev_x_q) && (Enemy_Y == prev_y_q) && (dir_q != DIR_STOP);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            prev_x_q <= 10'd0;
            prev_y_q <= 10'd0;
        end else begin
            prev_x_q <= prev_x_d;
            prev_y_q <= prev_y_d;
        end
    end
`else
    assign stall = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= ST_IDLE;
            dir_q      <= DIR_STOP;
            cnt_q      <= 8'd0;
            frame_q    <= 1'b0;
            lfsr_q     <= LFSR_SEED;
            type_q     <= 2'd0;
            fclk_dly_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            cnt_q      <= cnt_d;
            frame_q    <= frame_d;
            lfsr_q     <= lfsr_d;
            type_q     <= type_d;
            fclk_dly_q <= fclk_dly_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        frame_d = frame_q;
        type_d  = type_q;
        if (initialize || !active) begin
            if (initialize) type_d = Enemy_Type;
            state_d = ST_IDLE;
            dir_d   = DIR_STOP;
            cnt_d   = 8'd0;
            frame_d = 1'b0;
        end else if (frame_tick) begin
            frame_d = ~frame_q;
            case (type_q)
                TYPE_KEESE: begin
                    if (state_q == ST_WALK) begin
                        if (stall) begin
                            dir_d = roll_dir;
                            cnt_d = 8'd0;
                        end else if (cnt_q >= HOLD_LAST) begin
                            state_d = ST_IDLE;
                            dir_d   = DIR_STOP;
                            cnt_d   = 8'd0;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end else if (cnt_q >= PAUSE_LAST) begin
                        state_d = ST_WALK;
                        dir_d   = roll_dir;
                        cnt_d   = 8'd0;
                    end else begin
                        state_d = ST_IDLE;
                        dir_d   = DIR_STOP;
                        cnt_d   = cnt_q + 8'd1;
                    end
                end
                TYPE_REDEAD: begin
                    // Half speed: every odd frame-counter tick is a rest frame.
                    if (abs_dx <= RADIUS && abs_dy <= RADIUS) begin
                        state_d = ST_CHASE;
                        dir_d   = frame_q ? DIR_STOP : chase_dir;
                    end else begin
                        state_d = ST_IDLE;
                        dir_d   = DIR_STOP;
                    end
                end
                TYPE_SLIDER: begin
                    case (state_q)
                        ST_SLIDE: begin
                            if (stall) begin
                                state_d = ST_RETURN;
                                dir_d   = opp_dir;
                            end else if (cnt_q >= SLIDE_LAST) begin
                                state_d = ST_RETURN;
                                dir_d   = opp_dir;
                                cnt_d   = SLIDE_CNT;
                            end else begin
                                cnt_d = cnt_q + 8'd1;
                            end
                        end
                        ST_RETURN: begin
                            if (stall || cnt_q <= 8'd1) begin
                                state_d = ST_COOLDOWN;
                                dir_d   = DIR_STOP;
                                cnt_d   = 8'd0;
                            end else begin
                                cnt_d = cnt_q - 8'd1;
                            end
                        end
                        ST_COOLDOWN: begin
                            if (cnt_q >= PAUSE_LAST) begin
                                state_d = ST_IDLE;
                                cnt_d   = 8'd0;
                            end else begin
                                cnt_d = cnt_q + 8'd1;
                            end
                        end
                        default: begin
                            // Row alignment wins; a zero offset on the chosen axis stays idle.
                            state_d = ST_IDLE;
                            dir_d   = DIR_STOP;
                            cnt_d   = 8'd0;
                            if (abs_dy <= TOL) begin
                                if (x_dir != DIR_STOP) begin
                                    state_d = ST_SLIDE;
                                    dir_d   = x_dir;
                                end
                            end else if (abs_dx <= TOL && y_dir != DIR_STOP) begin
                                state_d = ST_SLIDE;
                                dir_d   = y_dir;
                            end
                        end
                    endcase
                end
                default: begin
                    state_d = ST_IDLE;
                    dir_d   = DIR_STOP;
                    cnt_d   = 8'd0;
                end
            endcase
        end
    end

    assign dir = dir_q;
endmodule

// File: tb/tb_enemy_ai_ctrl.sv
// tb/tb_enemy_ai_ctrl.sv - randomized self-checking bench for enemy_ai_ctrl against a period-based model
module tb_enemy_ai_ctrl;
    logic       clk = 1'b0;
    logic       Reset_n, frame_clk, initialize, active;
    logic [1:0] Enemy_Type;
    logic [9:0] Enemy_X, Enemy_Y, Link_X, Link_Y;
    logic [2:0] dir;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] lfsr_m;
    int          type_m, n_m;
    int          roll_m, slide_m;

    enemy_ai_ctrl dut (
        .Clk(clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .initialize(initialize),
        .active(active), .Enemy_Type(Enemy_Type), .Enemy_X(Enemy_X), .Enemy_Y(Enemy_Y),
        .Link_X(Link_X), .Link_Y(Link_Y), .dir(dir)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (tick %0d, t=%0t)", tag, got, exp, n_m, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int sgn_dir(input int d, input int pos, input int neg);
        return (d > 0) ? pos : ((d < 0) ? neg : 0);
    endfunction

    // Slider entry decision from the current geometry (row first).
    function automatic int slider_entry();
        int dx, dy;
        dx = int'(Link_X) - int'(Enemy_X);
        dy = int'(Link_Y) - int'(Enemy_Y);
        if (iabs(dy) <= 8) return sgn_dir(dx, 2, 1);
        if (iabs(dx) <= 8) return sgn_dir(dy, 3, 4);
        return 0;
    endfunction

    function automatic int opposite(input int d);
        case (d)
            1: return 2;
            2: return 1;
            3: return 4;
            4: return 3;
            default: return 0;
        endcase
    endfunction

    // Expected dir after the n_m-th tick since the last initialize / inactive period.
    function automatic int expected_dir();
        int dx, dy, ph;
        dx = int'(Link_X) - int'(Enemy_X);
        dy = int'(Link_Y) - int'(Enemy_Y);
        case (type_m)
            1: begin
                ph = (n_m - 1) % 48;
                if (ph == 15) roll_m = int'(lfsr_m[1:0]) + 1;
                return (ph >= 15 && ph <= 46) ? roll_m : 0;
            end
            2: begin
                if (iabs(dx) > 160 || iabs(dy) > 160 || (n_m % 2) == 0) return 0;
                return (iabs(dx) >= iabs(dy)) ? sgn_dir(dx, 2, 1) : sgn_dir(dy, 3, 4);
            end
            3: begin
                if (slide_m == 0) return 0;
                ph = (n_m - 1) % 113;
                if (ph < 48) return slide_m;
                if (ph < 96) return opposite(slide_m);
                return 0;
            end
            default: return 0;
        endcase
    endfunction

    task automatic do_tick(input string tag);
        int e;
        @(negedge clk);
        frame_clk = 1'b1;
        n_m++;
        e = expected_dir();
        lfsr_m = lfsr_next(lfsr_m);
        repeat ($urandom_range(1, 3)) @(negedge clk);
        frame_clk = 1'b0;
        check(tag, int'(dir), e);
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic do_init(input int t);
        @(negedge clk);
        Enemy_Type = 2'(t);
        initialize = 1'b1;
        @(negedge clk);
        initialize = 1'b0;
        type_m = t;
        n_m = 0;
        slide_m = slider_entry();
        check("init_dir", int'(dir), 0);
    endtask

    task automatic set_pos(input int ex, input int ey, input int lx, input int ly);
        Enemy_X = 10'(ex);
        Enemy_Y = 10'(ey);
        Link_X  = 10'(lx);
        Link_Y  = 10'(ly);
    endtask

    function automatic int clamp(input int v);
        return (v < 0) ? 0 : ((v > 1023) ? 1023 : v);
    endfunction

    initial begin
        int ex, ey;
        Reset_n = 1'b0; frame_clk = 1'b0; initialize = 1'b0; active = 1'b1;
        Enemy_Type = 2'd0;
        set_pos(100, 100, 500, 500);
        type_m = 0; n_m = 0; roll_m = 0; slide_m = 0;
        repeat (2) @(negedge clk);
        check("reset_dir", int'(dir), 0);
        Reset_n = 1'b1;
        lfsr_m = 16'hACE1;

        // Type is only taken at initialize; latched type 0 keeps dir at 0.
        repeat (3) do_tick("type0_dir");
        Enemy_Type = 2'd1;
        repeat (3) do_tick("unlatched_type_dir");
        do_init(0);
        repeat (3) do_tick("type0_init_dir");

        do_init(1);
        repeat (100) do_tick("keese_dir");

        // Asynchronous reset mid-walk, then LFSR seed visible through the next roll.
        do_init(1);
        repeat (20) do_tick("keese_pre_reset");
        @(negedge clk);
        Reset_n = 1'b0;
        #2;
        check("async_reset_dir", int'(dir), 0);
        @(negedge clk);
        Reset_n = 1'b1;
        lfsr_m = 16'hACE1;
        type_m = 0; n_m = 0;
        do_init(1);
        repeat (50) do_tick("keese_after_reset");

        // initialize coinciding with a frame tick.
        repeat (5) do_tick("keese_walk_pre");
        @(negedge clk);
        Enemy_Type = 2'd1; initialize = 1'b1; frame_clk = 1'b1;
        @(negedge clk);
        initialize = 1'b0; frame_clk = 1'b0;
        type_m = 1; n_m = 0;
        lfsr_m = lfsr_next(lfsr_m);
        check("init_tick_dir", int'(dir), 0);
        repeat (60) do_tick("keese_after_init_tick");

        set_pos(300, 200, 400, 220);
        do_init(2);
        repeat (6) do_tick("redead_right");
        set_pos(300, 200, 300, 400);
        repeat (3) do_tick("redead_far");
        for (int i = 0; i < 200; i++) begin
            ex = $urandom_range(0, 1023);
            ey = $urandom_range(0, 1023);
            set_pos(ex, ey, clamp(ex + $urandom_range(0, 400) - 200),
                    clamp(ey + $urandom_range(0, 400) - 200));
            if ($urandom_range(0, 7) == 0) Link_X = Enemy_X;
            if ($urandom_range(0, 7) == 0) Link_Y = Enemy_Y;
            do_tick("redead_rand");
        end

        // Dropping active mid-chase clears dir on the next edge.
        set_pos(300, 200, 250, 100);
        do_init(2);
        do_tick("redead_up_move");
        @(negedge clk);
        active = 1'b0;
        @(negedge clk);
        check("inactive_dir", int'(dir), 0);
        active = 1'b1;
        n_m = 0;
        repeat (6) do_tick("redead_resume");

        set_pos(192, 192, 50, 196);
        do_init(3);
        repeat (130) do_tick("slider_directed");
        for (int s = 0; s < 6; s++) begin
            ex = $urandom_range(16, 1000);
            ey = $urandom_range(16, 1000);
            case ($urandom_range(0, 2))
                0: set_pos(ex, ey, $urandom_range(0, 1023), clamp(ey + $urandom_range(0, 16) - 8));
                1: set_pos(ex, ey, clamp(ex + $urandom_range(0, 16) - 8), $urandom_range(0, 1023));
                default: set_pos(ex, ey, $urandom_range(0, 1023), $urandom_range(0, 1023));
            endcase
            do_init(3);
            repeat (120) do_tick("slider_rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
